// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: frame-format enums,
// the receiver state encoding and the receive FIFO entry layout.
package uart_pkg;

    localparam int RX_DATA_W = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRKWAIT
    } rx_state_e;

    typedef struct packed {
        logic                 brk;
        logic                 ferr;
        logic                 perr;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

    // Code 3 is an alias for "no parity".
    function automatic parity_e decode_parity(input logic [1:0] code);
        case (code)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int max_bits);
        if (bits < 4'd5) return 4'd5;
        if (int'(bits) > max_bits) return 4'(max_bits);
        return bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on head whenever
// the FIFO is non-empty and reads as zero when empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (level_q != '0);
        // A push on a full FIFO still lands when the head leaves in the same cycle.
        do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with runtime frame format, per-character error
// tags and a show-ahead receive FIFO feeding a ready/read consumer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic [DIV_W-1:0]           div,
    input  logic [3:0]                 cfg_bits,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop2,
    input  logic                       rx,
    input  logic                       read,
    output logic                       ready,
    output logic [DATA_W-1:0]          char,
    output logic                       perr,
    output logic                       ferr,
    output logic                       brk,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overrun,
    input  logic                       ovr_clr
);
    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
    localparam logic [TW-1:0] T_MID = TW'(OVS/2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);

    typedef struct packed {
        logic              brk;
        logic              ferr;
        logic              perr;
        logic [DATA_W-1:0] data;
    } entry_t;

    rx_state_e         state_q, state_d;
    logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_cfg_q, div_cfg_d;
    logic [TW-1:0]     tick_idx_q, tick_idx_d;
    logic [1:0]        samp_q, samp_d;
    logic [3:0]        bits_q, bits_d, bit_idx_q, bit_idx_d;
    parity_e           par_q, par_d;
    logic              stop2_q, stop2_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
    logic              overrun_q, overrun_d;
    logic              tick, start_det, maj, mid, bit_end, push, drop;
    entry_t            push_entry, head_entry;
    logic              fifo_full, fifo_empty;

    always_comb begin
        rx_s1_d    = rx;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        tick_idx_d = tick_idx_q;
        samp_d     = samp_q;
        div_cfg_d  = div_cfg_q;
        bits_d     = bits_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push       = 1'b0;

        tick      = (state_q != ST_IDLE) && (cnt_q == '0);
        start_det = (state_q == ST_IDLE) && rx_prev_q && !rx_s2_q;
        // Third sample is taken live at the mid tick so the decision is available there.
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
        mid       = tick && (tick_idx_q == T_MID);
        bit_end   = tick && (tick_idx_q == T_END);

        if (tick) begin
            cnt_d      = div_cfg_q;
            tick_idx_d = bit_end ? '0 : tick_idx_q + TW'(1);
            if (tick_idx_q == T_S0) samp_d[0] = rx_s2_q;
            if (tick_idx_q == T_S1) samp_d[1] = rx_s2_q;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    cnt_d      = div;
                    tick_idx_d = '0;
                    div_cfg_d  = div;
                    bits_d     = clamp_bits(cfg_bits, DATA_W);
                    par_d      = decode_parity(cfg_parity);
                    stop2_d    = cfg_stop2;
                    bit_idx_d  = '0;
                    data_d     = '0;
                    par_bit_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (mid && maj)   state_d = ST_IDLE;
                else if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (mid && (bit_idx_q == 4'(i))) data_d[i] = maj;
                end
                if (bit_end) begin
                    if (bit_idx_q == bits_q - 4'd1)
                        state_d = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
                    else
                        bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            ST_PARITY: begin
                if (mid) begin
                    par_bit_d = maj;
                    perr_d    = (^data_q) ^ maj ^ (par_q == PAR_ODD);
                end
                if (bit_end) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (mid) begin
                    ferr_d = ~maj;
                    if (!stop2_q) begin
                        push    = 1'b1;
                        state_d = maj ? ST_IDLE : ST_BRKWAIT;
                    end
                end else if (bit_end) begin
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (mid) begin
                    ferr_d  = ferr_q | ~maj;
                    push    = 1'b1;
                    state_d = (ferr_q | ~maj) ? ST_BRKWAIT : ST_IDLE;
                end
            end
            ST_BRKWAIT: begin
                if (rx_s2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        push_entry.brk  = ferr_d & ~(|data_q) & ~par_bit_q;
        push_entry.ferr = ferr_d;
        push_entry.perr = perr_q;
        push_entry.data = data_q;

        drop      = push && fifo_full && !(read && ready);
        overrun_d = overrun_q;
        if (ovr_clr) overrun_d = 1'b0;
        if (drop)    overrun_d = 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            cnt_q      <= div;
            div_cfg_q  <= div;
            tick_idx_q <= '0;
            samp_q     <= '0;
            bits_q     <= 4'd5;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            cnt_q      <= cnt_d;
            div_cfg_q  <= div_cfg_d;
            tick_idx_q <= tick_idx_d;
            samp_q     <= samp_d;
            bits_q     <= bits_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 3)
    ) u_fifo (
        .clk       (sclk),
        .srst      (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (read),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign ready   = ~fifo_empty;
    assign char    = head_entry.data;
    assign perr    = head_entry.perr;
    assign ferr    = head_entry.ferr;
    assign brk     = head_entry.brk;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a frame-level
// reference model (entry queue plus sticky overrun flag).
module tb_uart_rx_fifo;
    localparam int DATA_W = 8;
    localparam int OVS    = 16;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 16;
    localparam int LW     = $clog2(DEPTH+1);

    logic             sclk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] div = '0;
    logic [3:0]       cfg_bits = 4'd8;
    logic [1:0]       cfg_parity = 2'd0;
    logic             cfg_stop2 = 1'b0;
    logic             rx = 1'b1;
    logic             read = 1'b0;
    logic             ready;
    logic [DATA_W-1:0] char;
    logic             perr, ferr, brk;
    logic [LW-1:0]    level;
    logic             overrun;
    logic             ovr_clr = 1'b0;

    int   checks = 0;
    int   errors = 0;
    bit   quiet = 1'b0;
    logic [DATA_W+2:0] model_q[$];
    logic model_ovr = 1'b0;

    always #5 sclk = ~sclk;

    uart_rx_fifo #(.DATA_W(DATA_W), .OVS(OVS), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .sclk(sclk), .rst(rst), .div(div), .cfg_bits(cfg_bits), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .rx(rx), .read(read), .ready(ready), .char(char),
        .perr(perr), .ferr(ferr), .brk(brk), .level(level), .overrun(overrun),
        .ovr_clr(ovr_clr)
    );

    // Whenever the line is settled, every output must match the model.
    always @(negedge sclk) begin
        logic [DATA_W+2:0] head;
        logic [DATA_W+8:0] exp_v, act_v;
        if (quiet) begin
            head  = (model_q.size() != 0) ? model_q[0] : '0;
            exp_v = {1'(model_q.size() != 0), LW'(model_q.size()), model_ovr, head};
            act_v = {ready, level, overrun, brk, ferr, perr, char};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t got={rdy,lvl,ovr,brk,ferr,perr,char}=%h expected=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [DATA_W+2:0] e);
        if (model_q.size() < DEPTH) model_q.push_back(e);
        else model_ovr = 1'b1;
    endtask

    task automatic do_pop();
        read = 1'b1;
        hold(1);
        read = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic do_ovr_clr();
        ovr_clr = 1'b1;
        hold(1);
        ovr_clr = 1'b0;
        model_ovr = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] c, input logic p,
                              input logic f, input logic b);
        check_lit({name, "_ready"}, 32'(ready), 32'd1);
        check_lit({name, "_char"}, 32'(char), 32'(c));
        check_lit({name, "_perr"}, 32'(perr), 32'(p));
        check_lit({name, "_ferr"}, 32'(ferr), 32'(f));
        check_lit({name, "_brk"}, 32'(brk), 32'(b));
        do_pop();
    endtask

    // Drives one frame bit by bit and predicts the resulting FIFO entry.
    task automatic send_frame(input int bits_cfg, input int par_cfg, input bit st2, input int dv,
                              input logic [7:0] data, input bit flip, input bit s1, input bit s2);
        int nb, pm, bl, ones;
        logic [7:0] dm;
        logic pb, pe, fe, be;
        logic fr[$];
        nb = (bits_cfg < 5) ? 5 : ((bits_cfg > DATA_W) ? DATA_W : bits_cfg);
        pm = (par_cfg == 1) ? 1 : ((par_cfg == 2) ? 2 : 0);
        dm = data & 8'((1 << nb) - 1);
        pb = (pm == 1) ? ^dm : ((pm == 2) ? ~^dm : 1'b0);
        if (pm != 0) pb = pb ^ flip;
        cfg_bits = 4'(bits_cfg); cfg_parity = 2'(par_cfg); cfg_stop2 = st2; div = DIV_W'(dv);
        bl = OVS * (dv + 1);
        fr.push_back(1'b0);
        for (int i = 0; i < nb; i++) fr.push_back(dm[i]);
        if (pm != 0) fr.push_back(pb);
        fr.push_back(s1);
        if (st2) fr.push_back(s2);
        quiet = 1'b0;
        foreach (fr[i]) begin
            rx = fr[i];
            hold(bl);
            if (i == 0) begin
                cfg_bits = 4'($urandom); cfg_parity = 2'($urandom);
                cfg_stop2 = 1'($urandom); div = DIV_W'($urandom_range(0, 3));
            end
        end
        rx = 1'b1;
        hold(2 * bl);
        ones = $countones(dm) + int'(pb);
        pe = (pm == 1) ? (ones % 2 != 0) : ((pm == 2) ? (ones % 2 == 0) : 1'b0);
        fe = !s1 || (st2 && !s2);
        be = fe && (dm == 0) && !pb;
        model_push({be, fe, pe, dm});
        quiet = 1'b1;
    endtask

    initial begin
        hold(4);
        check_lit("rst_ready", 32'(ready), 0);
        check_lit("rst_level", 32'(level), 0);
        check_lit("rst_char", 32'(char), 0);
        check_lit("rst_flags", 32'({perr, ferr, brk, overrun}), 0);
        rst = 1'b0;
        hold(2);
        quiet = 1'b1;

        // 8N1 at div=0
        send_frame(8, 0, 0, 0, 8'h41, 0, 1, 1);
        check_lit("lat_ready", 32'(ready), 1);
        send_frame(8, 0, 0, 0, 8'h0A, 0, 1, 1);
        send_frame(8, 0, 0, 0, 8'h7E, 0, 1, 1);
        check_lit("three_level", 32'(level), 3);
        pop_expect("c41", 8'h41, 0, 0, 0);
        pop_expect("c0a", 8'h0A, 0, 0, 0);
        pop_expect("c7e", 8'h7E, 0, 0, 0);
        do_pop();
        check_lit("empty_pop_level", 32'(level), 0);

        // 7E1 good and bad parity
        send_frame(7, 1, 0, 0, 8'h35, 0, 1, 1);
        send_frame(7, 1, 0, 0, 8'h35, 1, 1, 1);
        pop_expect("par_ok", 8'h35, 0, 0, 0);
        pop_expect("par_bad", 8'h35, 1, 0, 0);

        // 8N2 with bad second stop, then a clean frame
        send_frame(8, 0, 1, 0, 8'h55, 0, 1, 0);
        send_frame(8, 0, 1, 0, 8'h66, 0, 1, 1);
        pop_expect("stop2_bad", 8'h55, 0, 1, 0);
        pop_expect("stop2_next", 8'h66, 0, 0, 0);

        // Line held low for three frame times
        cfg_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0; div = '0;
        quiet = 1'b0;
        rx = 1'b0;
        hold(30 * OVS);
        check_lit("brk_level_low", 32'(level), 1);
        model_push({1'b1, 1'b1, 1'b0, 8'h00});
        rx = 1'b1;
        hold(4 * OVS);
        quiet = 1'b1;
        check_lit("brk_level_high", 32'(level), 1);
        pop_expect("brk", 8'h00, 0, 1, 1);

        // Overflow: ten characters, no reads
        for (int i = 1; i <= 10; i++) send_frame(8, 0, 0, 0, 8'(i), 0, 1, 1);
        check_lit("ovf_level", 32'(level), 8);
        check_lit("ovf_overrun", 32'(overrun), 1);
        do_ovr_clr();
        check_lit("ovf_cleared", 32'(overrun), 0);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("ovf_c%0d", i), 8'(i), 0, 0, 0);

        // One-cycle glitch on the idle line
        quiet = 1'b0;
        rx = 1'b0;
        hold(1);
        rx = 1'b1;
        hold(4 * OVS);
        quiet = 1'b1;
        check_lit("glitch_level", 32'(level), 0);

        // Reset in the middle of the data bits with a character already queued
        send_frame(8, 0, 0, 0, 8'h11, 0, 1, 1);
        quiet = 1'b0;
        rx = 1'b0; hold(OVS);
        rx = 1'b1; hold(OVS);
        rx = 1'b0; hold(OVS / 2);
        rst = 1'b1; rx = 1'b1;
        hold(3);
        model_q.delete();
        model_ovr = 1'b0;
        rst = 1'b0;
        hold(3 * OVS);
        quiet = 1'b1;
        check_lit("midrst_level", 32'(level), 0);
        send_frame(8, 0, 0, 0, 8'hA5, 0, 1, 1);
        pop_expect("after_rst", 8'hA5, 0, 0, 0);

        // Random formats, data, errors and consumer activity
        for (int n = 0; n < 30; n++) begin
            send_frame($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom),
                       $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
            repeat ($urandom_range(0, 3)) do_pop();
            if ($urandom_range(0, 5) == 0) do_ovr_clr();
            hold($urandom_range(0, 5));
        end
        while (model_q.size() != 0) do_pop();
        hold(2);
        check_lit("final_level", 32'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the single-character UART receiver.
- Oversampled asynchronous serial receiver with runtime-selectable frame format: data bits, parity mode, stop bits.
- Per-character error tagging: framing, parity, break.
- Show-ahead receive FIFO in front of the existing ready/read consumer handshake.
- Sits between the rx pad and the character consumer logic, all on one system clock.

Parameters:
DATA_W, 8, maximum data bits per character; runtime bit count ranges 5..DATA_W.
OVS, 16, oversample ticks per bit; even, at least 8.
DEPTH, 8, FIFO entries; power of two, at least 2.
DIV_W, 16, divisor width.

Ports:
sclk  input  1  system clock
rst  input  1  synchronous reset, active-high
div  input  DIV_W  oversample tick period minus 1, in sclk cycles
cfg_bits  input  4  data bits per character, 5..DATA_W; values outside the range are clamped
cfg_parity  input  2  0 none, 1 even, 2 odd, 3 none
cfg_stop2  input  1  1 selects two stop bits
rx  input  1  asynchronous serial line, idle high
read  input  1  pop request; ignored while ready=0
ready  output  1  FIFO non-empty
char  output  DATA_W  head data, LSB = first received bit; unused upper bits are 0
perr  output  1  head parity error
ferr  output  1  head framing error
brk  output  1  head break (all data 0, parity 0 if enabled, and framing error)
level  output  $clog2(DEPTH+1)  FIFO occupancy
overrun  output  1  sticky; set when a character is dropped because the FIFO was full
ovr_clr  input  1  clears overrun; a set in the same cycle wins

Behaviour:
- rx passes through a 2-flop synchroniser. Both flops reset to 1, so reset never produces a false start.
- Tick generator: counter reloads from div and pulses tick for 1 cycle at 0. div=0 gives a tick every cycle. The counter is free-running outside IDLE and restarts on start detection, so bit timing is aligned to the falling edge.
- Config (div, cfg_*) is latched at start detection. Changes mid-frame have no effect on the current frame.
- Bit sampling: majority of 3 synchronised samples at ticks OVS/2-1, OVS/2 and OVS/2+1 of each bit, counting ticks 0..OVS-1 from the bit start.
- FSM:
  - IDLE: falling edge on synchronised rx -> START.
  - START: majority 1 -> IDLE (glitch, nothing pushed); else -> DATA at end of bit.
  - DATA: shift in cfg_bits bits, LSB first -> PARITY if enabled, else STOP1.
  - PARITY: even mode requires an even count of ones over data plus parity bit; odd mode requires an odd count. Mismatch sets perr.
  - STOP1: at mid-bit, a sampled 0 sets ferr.
    - cfg_stop2=0: push at mid-bit; -> BRKWAIT if ferr, else IDLE.
    - cfg_stop2=1: -> STOP2 at end of bit.
  - STOP2: a 0 at mid-bit also sets ferr; push at mid-bit; -> BRKWAIT if ferr, else IDLE.
  - BRKWAIT: wait for synchronised rx=1, then IDLE. This prevents a held-low line from generating repeated characters.
- Early return to IDLE at mid stop bit allows back-to-back frames with up to half a bit of clock mismatch.
- FIFO entry = {brk, ferr, perr, data}. Show-ahead: char/flags reflect the head whenever ready=1 and are 0 when empty.
- Pop occurs when read&ready. read while empty is a no-op.
- Push on full:
  - Without a same-cycle pop: entry dropped, overrun set, FIFO contents unchanged.
  - With a same-cycle pop: both happen, level unchanged, no overrun.
- Simultaneous push and pop on empty: push only, since ready=0 blocks the pop. ready rises next cycle.
- Latency: ready rises 1 sclk after the pushing mid-stop sample.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked separately.
- Reset values: ready 0, char 0, perr/ferr/brk 0, level 0, overrun 0. FSM returns to IDLE, tick counter reloads.
- Reset mid-frame discards the partial character and empties the FIFO.

Decomposition:
- Package uart_pkg:
  - parity enum: PAR_NONE, PAR_EVEN, PAR_ODD.
  - rx FSM state enum.
  - packed rx_entry_t struct {brk, ferr, perr, data}, parametrised via DATA_W localparam default.
- Sub-module sync_fifo (DEPTH, WIDTH; push/pop/full/empty/level; show-ahead). Natural to split out and reusable by the transmitter.
- Receiver FSM and tick generator stay in uart_rx_fifo.

Test Plan:
- div=0, OVS=16, 8N1: send 0x41, 0x0A, 0x7E -> ready rises each time; popped chars equal 0x41, 0x0A, 0x7E with perr=ferr=brk=0.
- cfg_bits=7, even parity: send 0x35 with correct parity bit 0, then 0x35 with parity bit 1 -> first entry perr=0, second perr=1, both char=0x35.
- 8N2: second stop bit driven 0 -> ferr=1 on that entry. The next normal frame is clean.
- rx held low 3 frame times -> exactly one entry with char=0, ferr=1, brk=1. No further entries until rx returns high and a new start arrives.
- DEPTH=8, never read, send 10 chars -> level=8, overrun=1, FIFO holds chars 1..8. ovr_clr clears overrun.
- 1-tick low glitch on idle line -> no entry. Reset asserted mid-DATA then released -> level=0 and the next full frame is received correctly.
